// File: rtl/player_sync_pkg.sv
// Shared definitions for the player clock-domain transfer blocks.
package player_sync_pkg;

  localparam int SAMPLE_W = 12;

  typedef logic [SAMPLE_W-1:0] sample_t;

  // Width of a word-count signal that must represent 0..depth inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stf_fifo.sv
// Single-clock show-ahead FIFO: the head word is always visible on rd_data.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module stf_fifo
  import player_sync_pkg::*;
#(
  parameter int N     = SAMPLE_W,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [N-1:0]              push_data,
  input  logic                      pop_req,
  output logic [N-1:0]              rd_data,
  output logic                      empty,
  output logic                      full,
  output logic                      drop,
  output logic [level_w(DEPTH)-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_w(DEPTH);

  logic [N-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             pop;
  logic             push_ok;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_W'(DEPTH));
  assign pop     = pop_req & ~empty;
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;
  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: contents are only visible while level is non-zero.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/stf_sync.sv
// Slow-to-fast sample transfer: synchronizes slowclk as a level, captures data
// on each of its rising edges into a show-ahead FIFO read via valid/ready.
module stf_sync
  import player_sync_pkg::*;
#(
  parameter int N     = SAMPLE_W,
  parameter int DEPTH = 4
) (
  input  logic                      fastclk,
  input  logic                      reset_n,
  input  logic                      slowclk,
  input  logic [N-1:0]              data,
  output logic [N-1:0]              out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [level_w(DEPTH)-1:0] level,
  output logic                      overrun,
  input  logic                      clr_overrun
);

  (* ASYNC_REG = "TRUE" *) logic s1_q;
  (* ASYNC_REG = "TRUE" *) logic s2_q;
  (* ASYNC_REG = "TRUE" *) logic s3_q;

  logic       armed_q, armed_d;
  logic [1:0] fill_q, fill_d;
  logic       overrun_q, overrun_d;
  logic       edge_det;
  logic       empty;
  logic       full;
  logic       drop;

  assign edge_det = armed_q & s2_q & ~s3_q;

  // Three-stage synchronizer; s2/s3 feed the rising-edge detector.
  always_ff @(posedge fastclk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= slowclk;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // The zeros loaded into s2 by reset are not real samples of slowclk, so arming
  // waits until s2 holds a genuine low; slowclk high at release is never captured.
  always_comb begin
    fill_d    = {fill_q[0], 1'b1};
    armed_d   = armed_q | (fill_q[1] & ~s2_q);
    overrun_d = overrun_q;
    if (clr_overrun) overrun_d = 1'b0;
    if (drop)        overrun_d = 1'b1;
  end

  // Arming state and the sticky overrun flag (a drop wins over a clear).
  always_ff @(posedge fastclk or negedge reset_n) begin
    if (!reset_n) begin
      fill_q    <= '0;
      armed_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      fill_q    <= fill_d;
      armed_q   <= armed_d;
      overrun_q <= overrun_d;
    end
  end

  // data has been stable for at least two fastclk cycles when edge_det fires.
  stf_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (fastclk),
    .rst_n     (reset_n),
    .push      (edge_det),
    .push_data (data),
    .pop_req   (out_ready),
    .rd_data   (out_data),
    .empty     (empty),
    .full      (full),
    .drop      (drop),
    .level     (level)
  );

  assign out_valid = ~empty;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_stf_sync.sv
// Bench for stf_sync: scoreboard of expected words checked on every pop.
module tb_stf_sync;
  import player_sync_pkg::*;

  localparam int N     = 12;
  localparam int DEPTH = 4;
  localparam int LW    = level_w(DEPTH);

  logic          fastclk = 1'b0;
  logic          reset_n;
  logic          slowclk;
  logic [N-1:0]  data;
  logic [N-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] level;
  logic          overrun;
  logic          clr_overrun;

  int            checks = 0;
  int            errors = 0;
  int            max_level = 0;
  logic [N-1:0]  sb [$];
  logic [N-1:0]  exp_word;

  stf_sync #(.N(N), .DEPTH(DEPTH)) dut (
    .fastclk     (fastclk),
    .reset_n     (reset_n),
    .slowclk     (slowclk),
    .data        (data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .level       (level),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 fastclk = ~fastclk;

  // Scoreboard: every accepted pop must match the oldest expected word.
  always @(negedge fastclk) begin
    if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL pop_unexpected: got word %h, required no word", out_data);
      end else begin
        exp_word = sb.pop_front();
        if (out_data !== exp_word) begin
          errors++;
          $display("[TB] FAIL pop_word: got %h, required %h", out_data, exp_word);
        end
      end
    end
    if (reset_n === 1'b1 && int'(level) > max_level) max_level = int'(level);
  end

  // Watchdog so the run can never hang.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge fastclk);
    #1;
  endtask

  // One slow period: rise with a new word, hold hi cycles, then low for lo cycles.
  task automatic slow_rise(input logic [N-1:0] val, input int hi, input int lo, input bit capture);
    slowclk = 1'b1;
    data    = val;
    if (capture) sb.push_back(val);
    repeat (hi) step();
    slowclk = 1'b0;
    repeat (lo) step();
  endtask

  // Bounded wait for the scoreboard to empty and the FIFO to go idle.
  task automatic wait_drain(output bit done);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge fastclk);
      if (sb.size() == 0 && out_valid === 1'b0) done = 1'b1;
    end
    step();
  endtask

  task automatic test_reset();
    int lat;
    bit found;
    bit done;
    reset_n = 1'b0; slowclk = 1'b1; data = '0; out_ready = 1'b0; clr_overrun = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b, required 0", out_valid); end
    checks++; if (level !== '0) begin errors++; $display("[TB] FAIL reset_level: got %0d, required 0", level); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b, required 0", overrun); end
    step();
    reset_n = 1'b1;
    repeat (8) step();
    checks++; if (out_valid !== 1'b0 || level !== '0) begin errors++; $display("[TB] FAIL high_at_release: got valid %b level %0d, required 0 0", out_valid, level); end
    slowclk = 1'b0;
    repeat (2) step();
    slowclk = 1'b1; data = 12'h0A5; sb.push_back(12'h0A5);
    found = 1'b0; lat = 0;
    for (int i = 1; i <= 6 && !found; i++) begin
      @(posedge fastclk);
      @(negedge fastclk);
      if (i == 2) slowclk = 1'b0;
      if (out_valid === 1'b1) begin found = 1'b1; lat = i; end
    end
    checks++; if (!found || lat < 2 || lat > 4) begin errors++; $display("[TB] FAIL first_latency: got %0d edges (found %b), required 3 +-1", lat, found); end
    checks++; if (out_data !== 12'h0A5) begin errors++; $display("[TB] FAIL first_word: got %h, required 0a5", out_data); end
    slowclk = 1'b0;
    step();
    out_ready = 1'b1;
    wait_drain(done);
    checks++; if (!done) begin errors++; $display("[TB] FAIL first_drain: got pending %0d, required 0", sb.size()); end
    out_ready = 1'b0;
  endtask

  task automatic test_stream();
    bit done;
    max_level = 0;
    out_ready = 1'b1;
    for (int v = 0; v < 16; v++) slow_rise(N'(v), 4, 4, 1'b1);
    wait_drain(done);
    checks++; if (!done) begin errors++; $display("[TB] FAIL stream_drain: got pending %0d, required 0", sb.size()); end
    checks++; if (max_level > 1) begin errors++; $display("[TB] FAIL stream_level: got max %0d, required <= 1", max_level); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL stream_overrun: got %b, required 0", overrun); end
    out_ready = 1'b0;
  endtask

  task automatic test_overrun();
    bit done;
    out_ready = 1'b0;
    for (int v = 1; v <= 6; v++) slow_rise(N'(v), 2, 2, v <= 4);
    @(negedge fastclk);
    checks++; if (level !== LW'(4)) begin errors++; $display("[TB] FAIL ovr_level: got %0d, required 4", level); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_flag: got %b, required 1", overrun); end
    checks++; if (out_data !== 12'h001) begin errors++; $display("[TB] FAIL ovr_head: got %h, required 001", out_data); end
    step();
    out_ready = 1'b1;
    wait_drain(done);
    checks++; if (!done) begin errors++; $display("[TB] FAIL ovr_drain: got pending %0d, required 0", sb.size()); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovr_empty: got valid %b, required 0", out_valid); end
    out_ready = 1'b0;
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    @(negedge fastclk);
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL clr_alone: got %b, required 0", overrun); end
    step();
  endtask

  task automatic test_full_pop();
    bit done;
    out_ready = 1'b0;
    for (int v = 'h10; v <= 'h13; v++) slow_rise(N'(v), 2, 2, 1'b1);
    slowclk = 1'b1; data = 12'h014; sb.push_back(12'h014);
    step();
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    slowclk = 1'b0;
    @(negedge fastclk);
    checks++; if (level !== LW'(4)) begin errors++; $display("[TB] FAIL fullpop_level: got %0d, required 4", level); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL fullpop_overrun: got %b, required 0", overrun); end
    checks++; if (out_data !== 12'h011) begin errors++; $display("[TB] FAIL fullpop_head: got %h, required 011", out_data); end
    step();
    out_ready = 1'b1;
    wait_drain(done);
    checks++; if (!done) begin errors++; $display("[TB] FAIL fullpop_drain: got pending %0d, required 0", sb.size()); end
    out_ready = 1'b0;
    step();
  endtask

  task automatic test_clr_drop();
    bit done;
    out_ready = 1'b0;
    for (int v = 'h20; v <= 'h23; v++) slow_rise(N'(v), 2, 2, 1'b1);
    slowclk = 1'b1; data = 12'h02F;
    step();
    step();
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    slowclk = 1'b0;
    @(negedge fastclk);
    checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL clr_vs_drop: got %b, required 1", overrun); end
    checks++; if (level !== LW'(4)) begin errors++; $display("[TB] FAIL drop_level: got %0d, required 4", level); end
    step();
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    @(negedge fastclk);
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL clr_after_drop: got %b, required 0", overrun); end
    step();
    out_ready = 1'b1;
    wait_drain(done);
    checks++; if (!done) begin errors++; $display("[TB] FAIL clr_drain: got pending %0d, required 0", sb.size()); end
    out_ready = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    bit done;
    out_ready = 1'b0;
    for (int v = 'h31; v <= 'h33; v++) slow_rise(N'(v), 2, 2, 1'b0);
    @(negedge fastclk);
    checks++; if (level !== LW'(3)) begin errors++; $display("[TB] FAIL mid_level_before: got %0d, required 3", level); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid: got %b, required 0", out_valid); end
    checks++; if (level !== '0) begin errors++; $display("[TB] FAIL mid_level: got %0d, required 0", level); end
    sb.delete();
    step();
    step();
    reset_n = 1'b1;
    repeat (4) step();
    slow_rise(12'h03C, 2, 2, 1'b1);
    out_ready = 1'b1;
    wait_drain(done);
    checks++; if (!done) begin errors++; $display("[TB] FAIL mid_drain: got pending %0d, required 0", sb.size()); end
    out_ready = 1'b0;
  endtask

  initial begin
    $display("[TB] starting stf_sync bench");
    test_reset();
    test_stream();
    test_overrun();
    test_full_pop();
    test_clr_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stf_sync.md
# stf_sync

Slow-to-fast sample transfer for the player datapath: brings an N-bit word launched on `slowclk` rising edges into the `fastclk` domain. The block runs entirely on `fastclk` and treats `slowclk` as an asynchronous level input. It synchronizes that level, detects its rising edges and captures `data` on each one into a small show-ahead FIFO. Consumers read the FIFO through a valid/ready handshake; the block is the counterpart of the fast-to-slow transfer path.

## Interface
Parameters:
- `N`, 12, sample width in bits.
- `DEPTH`, 4, FIFO depth in words; must be a power of two and at least 2.

Ports:
- `fastclk`  in  1  sole clock; every flop uses its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `slowclk`  in  1  slow-domain clock, sampled as asynchronous data.
- `data`  in  N  slow-domain word; changes only on `slowclk` rising edges.
- `out_data`  out  N  head-of-FIFO word; meaningful only while `out_valid` is 1.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  consumer accepts the head word.
- `level`  out  $clog2(DEPTH)+1  number of words held.
- `overrun`  out  1  sticky flag: at least one sample was dropped.
- `clr_overrun`  in  1  synchronous clear of `overrun`.

## Operation
- Synchronizer: `slowclk` passes through flops s1 -> s2 -> s3.
- Rising edge: `edge = armed & s2 & ~s3`.
- `armed` is 0 at reset. It sets on the first cycle with s2 = 0 and then stays 1. This means `slowclk` high at reset release never produces a capture; the first capture is the next real rising edge.
- Capture: on an `edge` cycle, `data` is sampled directly and pushed into the FIFO. The synchronizer delay of 2 or more cycles guarantees `data` is stable.
- Push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
- A push that is not accepted drops the sample. `overrun` is set on the next edge, contents stay unchanged and `level` stays at DEPTH.
- Pop: `out_valid & out_ready`. The read pointer advances.
- `out_ready` while empty has no effect.
- Simultaneous push and pop: `level` unchanged and both pointers advance, including when the FIFO is full.
- `overrun` is set by a drop and cleared by `clr_overrun`. If both occur in the same cycle, set wins.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. `level` distinguishes full from empty.
- Reset values: `out_valid` 0, `level` 0, `overrun` 0, pointers 0, s1/s2/s3 0, `armed` 0. `out_data` is don't-care while empty.
- Reset mid-operation discards all held words immediately, because the reset is asynchronous.

## Timing
- Latency from a `slowclk` rise to `out_valid`: let k be the first `fastclk` edge at which s1 captures 1.
  - s2 = 1 after edge k+1, so `edge` is high between edges k+1 and k+2.
  - The word is written at edge k+2.
  - `out_valid` is 1 after edge k+2, i.e. 3 `fastclk` edges (±1 for the sampling phase).
- `out_data` is combinational from the FIFO memory at the read pointer. The word is stable while `out_valid` is 1 and no pop occurs.
- Each rising edge of `slowclk` produces exactly one `edge` pulse of one cycle.
- Constraint: the `fastclk` frequency is at least 4 times the `slowclk` frequency, and `slowclk` high and low phases each last at least 2 `fastclk` periods.
- Sustained throughput is one word per slow period. The consumer may stall for up to DEPTH slow periods without overrun.

## Structure
- Shared package `player_sync_pkg` holds:
  - the default sample width constant (12);
  - a `sample_t` typedef, `logic [N-1:0]`;
  - a `level_w(depth)` function returning $clog2(depth)+1.
- Sub-module `stf_fifo`: a single-clock, show-ahead FIFO with push/pop, full/empty and `level`, parameterized by N and DEPTH.
- The top level holds the synchronizer, `armed`, edge detect and `overrun` logic.
- The synchronizer flops carry the team's asynchronous-register attribute for timing tooling.

## Test plan
- Reset release with `slowclk` held high, then a clean 4:1 `slowclk`, `data`=12'h0A5 on the next rise -> no capture before that rise; `out_data`=12'h0A5 and `out_valid`=1 after 3 (±1) `fastclk` edges.
- Ratio 8:1, `out_ready`=1, `data` counting 0..15 -> all 16 words read in order, `level` never exceeds 1, `overrun`=0.
- `out_ready`=0 for 6 slow edges, DEPTH=4, values 1..6 -> `level`=4, words 1..4 retained, `overrun`=1. After `out_ready` is raised, reads return 1,2,3,4, then `out_valid`=0.
- Full FIFO with `out_ready`=1 on the exact `edge` cycle -> `level` stays 4, the new word is appended and `overrun` stays 0.
- `clr_overrun` pulsed in the same cycle as a drop -> `overrun` remains 1. `clr_overrun` pulsed alone -> `overrun`=0 on the next cycle.
- `reset_n` asserted with 3 words held, between two `fastclk` edges -> `out_valid`=0 and `level`=0 immediately. After release, the first word delivered is the one from the next real `slowclk` rise.
